alu: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_comb.sv | 48 ++++
 rtl/alu.sv | 30 +++
 tb/tb_alu.sv | 105 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: data width and opcode encodings shared by the ALU files
package alu_pkg;
  localparam int DW = 32;
  localparam logic [3:0] ALUOP_AND              = 4'b1000;
  localparam logic [3:0] ALUOP_OR               = 4'b1001;
  localparam logic [3:0] ALUOP_NOR              = 4'b1010;
  localparam logic [3:0] ALUOP_NAND             = 4'b1011;
  localparam logic [3:0] ALUOP_XOR              = 4'b1100;
  localparam logic [3:0] ALUOP_SUM              = 4'b0100;
  localparam logic [3:0] ALUOP_SUB              = 4'b0101;
  localparam logic [3:0] ALUOP_MUL              = 4'b0110;
  localparam logic [3:0] ALUOP_LOG_SHFT_RIGHT   = 4'b0000;
  localparam logic [3:0] ALUOP_LOG_SHFT_LEFT    = 4'b0001;
  localparam logic [3:0] ALUOP_ARTHM_SHFT_RIGHT = 4'b0010;
  localparam logic [3:0] ALUOP_ARTHM_SHFT_LEFT  = 4'b0011;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational datapath producing next result, ovf and zero
module alu_comb
  import alu_pkg::*;
(
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  logic [3:0]    alu_op,
  output logic [DW-1:0] result,
  output logic          ovf,
  output logic          zero
);
  logic [DW-1:0]   sum;
  logic [DW-1:0]   dif;
  logic [2*DW-1:0] prod;
  logic [4:0]      sh;
  assign sum  = op1 + op2;
  assign dif  = op1 - op2;
  assign prod = {{DW{op1[DW-1]}}, op1} * {{DW{op2[DW-1]}}, op2};
  assign sh   = op2[4:0];
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_op)
      ALUOP_AND:  result = op1 & op2;
      ALUOP_OR:   result = op1 | op2;
      ALUOP_NOR:  result = ~(op1 | op2);
      ALUOP_NAND: result = ~(op1 & op2);
      ALUOP_XOR:  result = op1 ^ op2;
      ALUOP_SUM: begin
        result = sum;
        ovf    = (op1[DW-1] == op2[DW-1]) && (sum[DW-1] != op1[DW-1]);
      end
      ALUOP_SUB: begin
        result = dif;
        ovf    = (op1[DW-1] != op2[DW-1]) && (dif[DW-1] != op1[DW-1]);
      end
      ALUOP_MUL: begin
        result = prod[DW-1:0];
        ovf    = ~(&prod[2*DW-1:DW-1] | ~|prod[2*DW-1:DW-1]);
      end
      ALUOP_LOG_SHFT_RIGHT:   result = op1 >> sh;
      ALUOP_ARTHM_SHFT_RIGHT: result = $signed(op1) >>> sh;
      ALUOP_LOG_SHFT_LEFT, ALUOP_ARTHM_SHFT_LEFT: result = op1 << sh;
      default: ;
    endcase
  end
  assign zero = ~|result;
endmodule

// File: rtl/alu.sv
// alu: registered 32-bit integer ALU with zero and signed-overflow flags
module alu
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  logic [3:0]    alu_op,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          ovf
);
  logic [DW-1:0] result_d;
  logic          ovf_d;
  logic          zero_d;
  alu_comb u_comb (
    .op1    (op1),
    .op2    (op2),
    .alu_op (alu_op),
    .result (result_d),
    .ovf    (ovf_d),
    .zero   (zero_d)
  );
  always_ff @(posedge clk) begin
    result <= rst ? '0   : result_d;
    ovf    <= rst ? 1'b0 : ovf_d;
    zero   <= rst ? 1'b1 : zero_d;
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench driving directed ALU vectors
module tb_alu;
  import alu_pkg::*;
  typedef struct {
    logic [31:0] r;
    logic        o;
    logic        z;
    string       n;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [3:0]  alu_op = 4'b1111;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        issued = 1'b0;
  logic        pend;
  exp_t        q[$];
  exp_t        e;
  int          total = 0;
  int          passed = 0;
  alu dut (
    .clk    (clk),
    .rst    (rst),
    .op1    (op1),
    .op2    (op2),
    .alu_op (alu_op),
    .result (result),
    .zero   (zero),
    .ovf    (ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pend = issued;
    #1;
    if (pend) begin
      total++;
      if (q.size() == 0) begin
        $display("FAIL %s: got %h/%b/%b but no expected entry queued", "underflow", result, ovf, zero);
      end else begin
        e = q.pop_front();
        if ({result, ovf, zero} !== {e.r, e.o, e.z})
          $display("FAIL %s: got result=%h ovf=%b zero=%b, need result=%h ovf=%b zero=%b",
                   e.n, result, ovf, zero, e.r, e.o, e.z);
        else
          passed++;
      end
    end
  end
  task automatic issue(input logic r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eo, input logic ez, input string n);
    exp_t x;
    @(negedge clk);
    rst = r;
    alu_op = op;
    op1 = a;
    op2 = b;
    issued = 1'b1;
    x.r = er; x.o = eo; x.z = ez; x.n = n;
    q.push_back(x);
  endtask
  initial begin
    issue(1, ALUOP_SUM, 32'h1, 32'h1, 32'h0, 0, 1, "reset_initial");
    issue(0, ALUOP_SUM, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, "sum_pos_ovf");
    issue(0, ALUOP_SUM, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1, 0, "sum_neg_ovf");
    issue(0, ALUOP_SUM, 32'd100, 32'd50, 32'd150, 0, 0, "sum_plain");
    issue(0, ALUOP_SUB, 32'd25, 32'd25, 32'h0, 0, 1, "sub_zero");
    issue(0, ALUOP_SUB, 32'd50, 32'd100, 32'hFFFFFFCE, 0, 0, "sub_neg");
    issue(0, ALUOP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0, "sub_neg_ovf");
    issue(0, ALUOP_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 0, "sub_pos_ovf");
    issue(0, ALUOP_MUL, 32'd10, 32'hFFFFFFFB, 32'hFFFFFFCE, 0, 0, "mul_signed");
    issue(0, ALUOP_MUL, 32'h00010000, 32'h00010000, 32'h0, 1, 1, "mul_wrap_zero");
    issue(0, ALUOP_MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "mul_minint");
    issue(0, ALUOP_AND, 32'h0F0F0F0F, 32'hFFFF0000, 32'h0F0F0000, 0, 0, "and");
    issue(0, ALUOP_OR, 32'h0F0F0F0F, 32'hFFFF0000, 32'hFFFF0F0F, 0, 0, "or");
    issue(0, ALUOP_XOR, 32'h0F0F0F0F, 32'hFFFF0000, 32'hF0F00F0F, 0, 0, "xor");
    issue(0, ALUOP_NAND, 32'h0F0F0F0F, 32'hFFFF0000, 32'hF0F0FFFF, 0, 0, "nand");
    issue(0, ALUOP_NOR, 32'h0F0F0F0F, 32'hFFFF0000, 32'h0000F0F0, 0, 0, "nor");
    issue(0, ALUOP_LOG_SHFT_LEFT, 32'h0000000F, 32'd4, 32'h000000F0, 0, 0, "lsl");
    issue(0, ALUOP_ARTHM_SHFT_LEFT, 32'h0000000F, 32'd4, 32'h000000F0, 0, 0, "asl");
    issue(0, ALUOP_LOG_SHFT_RIGHT, 32'hF000000A, 32'd4, 32'h0F000000, 0, 0, "lsr");
    issue(0, ALUOP_ARTHM_SHFT_RIGHT, 32'hF000000A, 32'd4, 32'hFF000000, 0, 0, "asr");
    issue(0, ALUOP_LOG_SHFT_LEFT, 32'h0000000F, 32'h00000024, 32'h000000F0, 0, 0, "lsl_amt_mask");
    issue(0, ALUOP_ARTHM_SHFT_RIGHT, 32'hF000000A, 32'hFFFFFFE4, 32'hFF000000, 0, 0, "asr_amt_mask");
    issue(0, ALUOP_LOG_SHFT_RIGHT, 32'h12345678, 32'h00000020, 32'h12345678, 0, 0, "shift_by_zero");
    issue(0, 4'b1111, 32'h12345678, 32'h1, 32'h0, 0, 1, "undef_1111");
    issue(0, 4'b0111, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 0, 1, "undef_0111");
    issue(0, ALUOP_SUM, 32'd3, 32'd4, 32'd7, 0, 0, "pre_reset");
    issue(1, ALUOP_SUM, 32'h7FFFFFFF, 32'h1, 32'h0, 0, 1, "reset_midstream");
    issue(0, ALUOP_XOR, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 0, 0, "post_reset");
    issue(0, ALUOP_SUB, 32'd1, 32'd2, 32'hFFFFFFFF, 0, 0, "b2b_sub");
    @(negedge clk);
    issued = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expected results left unchecked, need 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
